// File: rtl/compressor_test_pkg.sv
// Shared types and defaults for the compressor result serializer.
// State encoding and default column count live here.
package compressor_test_pkg;

   localparam int DST_W_DEF  = 26;
   localparam int SETTLE_DEF = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SHIFT,
      DONE
   } ser_state_t;

endpackage

// File: rtl/result_misr.sv
// Rotate-xor signature register folding each captured result vector.
// Instantiated by result_serializer only when RESULT_MISR_EN is defined.
module result_misr
   import compressor_test_pkg::*;
#(
   parameter int DST_W = DST_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DST_W-1:0] din,
   output logic [DST_W-1:0] sig
);

   logic [DST_W-1:0] r_sig;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sig <= '0;
      end else if (load) begin
         r_sig <= {r_sig[DST_W-2:0], r_sig[DST_W-1]} ^ din;
      end
   end

   assign sig = r_sig;

endmodule

// File: rtl/result_serializer.sv
// Captures compressor dst columns and shifts them out LSB first on a ready/valid pin.
// Optional signature port and MISR enabled by defining RESULT_MISR_EN.
module result_serializer
   import compressor_test_pkg::*;
#(
   parameter int DST_W  = DST_W_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DST_W-1:0] din,
   output logic             dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done
`ifdef RESULT_MISR_EN
   ,
   output logic [DST_W-1:0] sig
`endif
);

   localparam int BIT_W = $clog2(DST_W + 1);
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DST_W - 1);
   localparam logic [CNT_W-1:0] CNT_INIT =
      CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

   ser_state_t       r_state;
   logic [DST_W-1:0] r_shreg;
   logic [CNT_W-1:0] r_cnt;
   logic [BIT_W-1:0] r_bitcnt;
   logic             r_dout;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;

   logic w_accept;
   logic w_capture;
   logic w_beat;

   assign w_accept  = (r_state == IDLE) && start;
   // Zero settle captures on the accepting edge itself
   assign w_capture = (w_accept && (SETTLE == 0)) ||
                      ((r_state == WAIT) && (r_cnt == '0));
   assign w_beat    = r_valid && dout_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_bitcnt <= '0;
         r_dout   <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_capture) begin
            r_state  <= SHIFT;
            r_shreg  <= din;
            r_bitcnt <= '0;
            r_dout   <= din[0];
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_INIT;
                     r_busy  <= 1'b1;
                  end
               end
               WAIT: begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
               SHIFT: begin
                  if (w_beat) begin
                     r_shreg  <= r_shreg >> 1;
                     r_bitcnt <= r_bitcnt + BIT_W'(1);
                     if (r_bitcnt == LAST_BIT) begin
                        r_state <= DONE;
                        r_dout  <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_dout <= r_shreg[1];
                     end
                  end
               end
               DONE: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign busy       = r_busy;
   assign done       = r_done;

`ifdef RESULT_MISR_EN
   result_misr #(
      .DST_W(DST_W)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .load(w_capture),
      .din (din),
      .sig (sig)
   );
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed frame table, corner sequences, random vs model.
// Define RESULT_MISR_EN to also exercise the signature port.
module tb_result_serializer;
   import compressor_test_pkg::*;

   localparam int W  = 26;
   localparam int ST = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] din;
   logic         dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         busy;
   logic         done;
`ifdef RESULT_MISR_EN
   logic [W-1:0] sig;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   result_serializer #(
      .DST_W (W),
      .SETTLE(ST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .busy      (busy),
      .done      (done)
`ifdef RESULT_MISR_EN
      ,
      .sig       (sig)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: a bit queue plus a capture countdown
   bit           mq[$];
   bit           m_active;
   bit           m_done;
   int           m_wait;
   logic [W-1:0] m_sig;

   task automatic m_capture(input logic [W-1:0] d);
      mq.delete();
      for (int i = 0; i < W; i++) mq.push_back(d[i]);
      m_sig = {m_sig[W-2:0], m_sig[W-1]} ^ d;
   endtask

   task automatic m_step(input bit r, input bit s, input logic [W-1:0] d,
                         input bit rdy);
      if (r) begin
         mq.delete();
         m_active = 0; m_done = 0; m_wait = 0; m_sig = '0;
      end else if (m_done) begin
         m_done = 0; m_active = 0;
      end else if (!m_active) begin
         if (s) begin
            m_active = 1; m_wait = ST;
            if (ST == 0) m_capture(d);
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) m_capture(d);
      end else if (rdy) begin
         void'(mq.pop_front());
         if (mq.size() == 0) m_done = 1;
      end
   endtask

   function automatic logic [3:0] m_exp();
      bit v;
      v = m_active && !m_done && (m_wait == 0) && (mq.size() > 0);
      return {v ? mq[0] : 1'b0, v, m_active, m_done};
   endfunction

   // Runs one frame from a negedge; d1 replaces d0 just before the capture edge
   task automatic run_frame(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input bit tog, output logic [W-1:0] word,
                            output int beats, output int first_v,
                            output int ndone, output int nvalid,
                            output int last_k, output int done_k,
                            output bit stable_ok, output bit ended);
      bit   pv, pr;
      logic pd;
      word = '0; beats = 0; first_v = -1; ndone = 0; nvalid = 0;
      last_k = -1; done_k = -1; stable_ok = 1; ended = 0;
      pv = 0; pd = 0; pr = 1;
      din = d0; start = 1; dout_ready = 1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         start = 0;
         if (k == 1) din = d1;
         if (done) begin ndone++; done_k = k; end
         if (!busy) begin ended = 1; break; end
         if (dout_valid) begin
            nvalid++;
            if (first_v < 0) first_v = k;
         end
         if (pv && !pr && (!dout_valid || dout !== pd)) stable_ok = 0;
         pr = tog ? ~pr : 1'b1;
         dout_ready = pr;
         if (dout_valid && pr) begin
            if (beats < W) word[beats] = dout;
            beats++;
            last_k = k;
         end
         pv = dout_valid; pd = dout;
      end
      dout_ready = 1;
   endtask

   typedef struct {
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      bit           tog;
      logic [W-1:0] exp_word;
      int           exp_nvalid;
   } vec_t;

   vec_t vt[5];

   initial begin
      logic [W-1:0] word;
      int beats, first_v, ndone, nvalid, last_k, done_k, nb, nd, nv;
      bit stable_ok, ended, ok;

      vt[0] = '{26'h0000005, 26'h0000005, 1'b0, 26'h0000005, 26};
      vt[1] = '{26'h0000005, 26'h0000005, 1'b1, 26'h0000005, 52};
      vt[2] = '{26'h0000005, 26'h3FFFFFF, 1'b0, 26'h3FFFFFF, 26};
      vt[3] = '{26'h2AAAAAA, 26'h2AAAAAA, 1'b1, 26'h2AAAAAA, 52};
      vt[4] = '{26'h3FFFFFF, 26'h0000000, 1'b0, 26'h0000000, 26};

      rst = 1; start = 0; din = '0; dout_ready = 0;
      repeat (2) @(negedge clk);
      chk("reset_outs", {28'b0, dout, dout_valid, busy, done}, 32'h0);
`ifdef RESULT_MISR_EN
      chk("reset_sig", 32'(sig), 32'h0);
`endif
      rst = 0;

      foreach (vt[i]) begin
         run_frame(vt[i].d0, vt[i].d1, vt[i].tog, word, beats, first_v,
                   ndone, nvalid, last_k, done_k, stable_ok, ended);
         chk($sformatf("v%0d_ended", i), 32'(ended), 32'd1);
         chk($sformatf("v%0d_word", i), 32'(word), 32'(vt[i].exp_word));
         chk($sformatf("v%0d_beats", i), beats, W);
         chk($sformatf("v%0d_first_valid", i), first_v, ST);
         chk($sformatf("v%0d_nvalid", i), nvalid, vt[i].exp_nvalid);
         chk($sformatf("v%0d_ndone", i), ndone, 1);
         chk($sformatf("v%0d_done_lat", i), done_k, last_k + 1);
         chk($sformatf("v%0d_stable", i), 32'(stable_ok), 32'd1);
      end

      // start held high: one frame, the next accepted right after DONE
      din = 26'h5; start = 1; dout_ready = 1; ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
      chk("hold_done1", 32'(ok), 32'd1);
      @(negedge clk);
      chk("hold_idle_gap", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("hold_restart", {30'b0, busy, dout_valid}, 32'd2);
      start = 0; ok = 0; nd = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) nd++;
         if (!busy) begin ok = 1; break; end
      end
      chk("hold_f2_end", 32'(ok), 32'd1);
      chk("hold_f2_done", nd, 1);
      repeat (5) @(negedge clk);
      chk("hold_no_third", {31'b0, busy}, 32'd0);

      // reset after the 10th beat aborts the frame
      din = 26'h5; start = 1; dout_ready = 1; nb = 0; ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         start = 0;
         if (dout_valid) nb++;
         if (nb == 11) begin ok = 1; break; end
      end
      chk("rst_reach10", 32'(ok), 32'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rst_abort", {28'b0, dout, dout_valid, busy, done}, 32'h0);
      nd = 0; nv = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) nd++;
         if (dout_valid) nv++;
      end
      chk("rst_no_done", nd, 0);
      chk("rst_no_bits", nv, 0);

`ifdef RESULT_MISR_EN
      rst = 1;
      @(negedge clk);
      rst = 0;
      run_frame(26'h1, 26'h1, 1'b0, word, beats, first_v, ndone, nvalid,
                last_k, done_k, stable_ok, ended);
      chk("misr_f1", 32'(sig), 32'h1);
      run_frame(26'h2, 26'h2, 1'b0, word, beats, first_v, ndone, nvalid,
                last_k, done_k, stable_ok, ended);
      chk("misr_f2", 32'(sig), 32'h0);
`endif

      // random traffic against the queue model
      rst = 1; start = 0; dout_ready = 0;
      m_step(1, 0, din, 0);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("rand_outs", {28'b0, dout, dout_valid, busy, done},
             {28'b0, m_exp()});
`ifdef RESULT_MISR_EN
         chk("rand_sig", 32'(sig), 32'(m_sig));
`endif
         rst        = ($urandom_range(0, 199) == 0);
         start      = ($urandom_range(0, 3) == 0);
         dout_ready = ($urandom_range(0, 2) != 0);
         din        = W'($urandom);
         m_step(rst, start, din, dout_ready);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
